dmem_responder: RTL

- Target-side data memory for the rv32 pipeline. It answers load/store requests issued by the access stage over a valid/ready request channel and a one-cycle response pulse.
- Replaces the zero-latency dmem. Supports byte, half and word sizes, sign or zero extension on loads, and configurable wait states.
- While a request is outstanding, the core's stall logic holds the pipeline on req_ready/rsp_valid.

---
 rtl/rv32_mem_pkg.sv | 51 +++++
 rtl/mem_lane_align.sv | 20 ++
 rtl/dmem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared memory-access definitions for the rv32 load/store path:
// size codes, responder FSM states, byte-enable and load-extension helpers.
package rv32_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {off, 3'b000};
        res = '0;
        unique case (size)
            SZ_BYTE: res = uns ? {24'd0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = uns ? {16'd0, sh[15:0]}
                               : {{16{sh[15]}}, sh[15:0]};
            SZ_WORD: res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit array word and right-aligned
// request/response data.
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wlane,
    output logic [31:0] o_rdata
);

    assign o_be    = byte_en(i_size, i_off);
    assign o_wlane = i_wdata << {i_off, 3'b000};
    assign o_rdata = load_ext(i_rword, i_size, i_off, i_unsigned);

endmodule

// File: rtl/dmem_responder.sv
// Data memory target with valid/ready request channel, programmable
// wait states and a single-cycle response pulse.
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0] CNT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t r_state;
    dmem_state_t w_state_nx;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_resp;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;
    logic [31:0]   w_rdata;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_resp    = (r_state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nx = WAIT;
                        w_cnt_nx   = CNT_LOAD;
                    end else begin
                        w_state_nx = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) w_state_nx = RESP;
                else               w_cnt_nx   = r_cnt - 4'd1;
            end
            RESP:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // All checks use the captured request so inputs may change after accept.
    always_comb begin
        w_err = 1'b0;
        if (r_size == 2'd3)
            w_err = 1'b1;
        if ((r_size == SZ_HALF) && r_addr[0])
            w_err = 1'b1;
        if ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00))
            w_err = 1'b1;
        if ({1'b0, r_addr} >= LIMIT)
            w_err = 1'b1;
    end

    assign w_idx   = r_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];

    mem_lane_align u_align (
        .i_size     (r_size),
        .i_off      (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wlane    (w_wlane),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_resp && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

    assign rsp_valid = w_resp;
    assign rsp_err   = w_resp && w_err;
    assign rsp_rdata = (w_resp && !r_we && !w_err) ? w_rdata : 32'd0;

endmodule
